// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//   SZ_*        : request size encodings (byte, half, word, double)
//   state_e     : responder FSM state encoding
//   size_bytes  : access width in bytes for a size encoding
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extender.
//   data        : gathered little-endian bytes, right-aligned
//   size        : access size encoding
//   is_unsigned : zero-extend when 1, sign-extend when 0 (ignored for doubles)
//   result      : extended 64-bit load value
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] result
);

  always_comb begin
    result = data;
    unique case (size)
      SZ_B:    result = {{56{~is_unsigned & data[7]}}, data[7:0]};
      SZ_H:    result = {{48{~is_unsigned & data[15]}}, data[15:0]};
      SZ_W:    result = {{32{~is_unsigned & data[31]}}, data[31:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-addressed little-endian RAM behind a one-at-a-time
// valid/ready request channel and a valid/ready response channel.
//   clk, reset               : clock, synchronous active-high reset (clears the RAM)
//   req_valid/req_ready      : request handshake; ready only while idle
//   req_write/addr/wdata/size/unsigned : request fields, captured on acceptance
//   resp_valid/resp_ready    : response handshake; fields held until taken
//   resp_rdata/resp_err      : load data (0 for stores/errors), access error
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CntInit = CW'(LATENCY - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          write_q;
  logic [63:0]   addr_q;
  logic [63:0]   wdata_q;
  logic [1:0]    size_q;
  logic          unsigned_q;
  logic [63:0]   rdata_q;
  logic          err_q;
  logic [7:0]    mem_q [DEPTH_BYTES];

  logic [3:0]    n_bytes;
  logic [64:0]   end_addr;
  logic          acc_err;
  logic [AW-1:0] base;
  logic [63:0]   gathered;
  logic [63:0]   ext_data;

  assign n_bytes  = size_bytes(size_q);
  // 65-bit sum so addresses near 2^64 cannot wrap back into range
  assign end_addr = {1'b0, addr_q} + 65'(n_bytes);
  assign acc_err  = ((addr_q[3:0] & (n_bytes - 4'd1)) != 4'd0) ||
                    (end_addr > 65'(DEPTH_BYTES));
  assign base     = addr_q[AW-1:0];

  // Gather 8 bytes unconditionally (wrapping); only the low n are meaningful
  always_comb begin
    gathered = '0;
    for (int i = 0; i < 8; i++) begin
      gathered[8*i +: 8] = mem_q[base + AW'(i)];
    end
  end

  load_extend u_load_extend (
    .data        (gathered),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_B;
      unsigned_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q    <= req_write;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            cnt_q      <= CntInit;
            // Always pass through BUSY so the access lands LATENCY edges later
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
            if (acc_err) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              err_q <= 1'b0;
              if (write_q) begin
                rdata_q <= '0;
                for (int i = 0; i < 8; i++) begin
                  if (4'(i) < n_bytes) begin
                    mem_q[base + AW'(i)] <= wdata_q[8*i +: 8];
                  end
                end
              end else begin
                rdata_q <= ext_data;
              end
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
